// File: rtl/multdiv_seq_param_if.sv
// ---------------------------------------------------------------------------
// multdiv_seq_param_if
// Bundles the EX-stage control, operand and result signals of the sequential
// multiply/divide unit.
//   ALUCtl_i  [4:1]  op control: [4:3]=11 start, [4:3]=10 move-from,
//                    [2]=unsigned, [1]=DIV / read LO
//   Op1_i     WIDTH  multiplicand / dividend
//   Op2_i     WIDTH  multiplier / divisor
//   Res_o     WIDTH  move-from data (HI or LO), 0 when not a move-from
//   Stall_o   1      pipeline hold request
//   DivZero_o 1      sticky divide-by-zero flag
// master: the pipeline side (drives control/operands)
// slave : the multiply/divide unit
// ---------------------------------------------------------------------------
interface multdiv_seq_param_if #(
    parameter int WIDTH = 32
);
    logic [4:1]       ALUCtl_i;
    logic [WIDTH-1:0] Op1_i;
    logic [WIDTH-1:0] Op2_i;
    logic [WIDTH-1:0] Res_o;
    logic             Stall_o;
    logic             DivZero_o;

    modport master (
        output ALUCtl_i, Op1_i, Op2_i,
        input  Res_o, Stall_o, DivZero_o
    );

    modport slave (
        input  ALUCtl_i, Op1_i, Op2_i,
        output Res_o, Stall_o, DivZero_o
    );
endinterface

// File: rtl/multdiv_seq_param.sv
// ---------------------------------------------------------------------------
// multdiv_seq_param
// Sequential multiply/divide unit for the EX stage. Signed/unsigned multiply
// uses radix-4 Booth recoding; signed/unsigned divide is a restoring divider
// working on magnitudes followed by a single sign-fix cycle. Results land in
// the HI/LO registers and are read back with move-from operations.
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     multdiv_seq_param_if.slave (ALUCtl_i, Op1_i, Op2_i in;
//           Res_o, Stall_o, DivZero_o out)
// ---------------------------------------------------------------------------
module multdiv_seq_param #(
    parameter int WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    multdiv_seq_param_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam int AW = 2 * WIDTH + 3;
    localparam int MW = WIDTH + 2;

    localparam logic [CW-1:0] K_MS = CW'(WIDTH / 2);
    localparam logic [CW-1:0] K_MU = CW'(WIDTH / 2 + 1);
    localparam logic [CW-1:0] K_D  = CW'(WIDTH + 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DIV
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [CW-1:0]    r_count;
    logic [AW-1:0]    r_acc;
    logic [MW-1:0]    r_mcand;
    logic             r_unsigned;
    logic             r_negQ;
    logic             r_negR;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_divZero;

    logic             w_start;
    logic             w_moveFrom;
    logic             w_isDiv;
    logic             w_isUnsigned;
    logic             w_divByZero;
    logic             w_op1Neg;
    logic             w_op2Neg;
    logic [WIDTH-1:0] w_op1Mag;
    logic [WIDTH-1:0] w_op2Mag;
    logic [MW-1:0]    w_mcandInit;

    logic             w_corrStep;
    logic [2:0]       w_booth;
    logic [MW-1:0]    w_pp;
    logic [MW-1:0]    w_aSum;
    logic [AW-1:0]    w_accSum;
    logic [AW-1:0]    w_accShift;
    logic [AW-1:0]    w_accNext;

    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;
    logic [WIDTH-1:0] w_remNext;
    logic [WIDTH-1:0] w_quoNext;

    assign w_start      = (bus.ALUCtl_i[4:3] == 2'b11);
    assign w_moveFrom   = (bus.ALUCtl_i[4:3] == 2'b10);
    assign w_isDiv      = bus.ALUCtl_i[1];
    assign w_isUnsigned = bus.ALUCtl_i[2];
    assign w_divByZero  = w_isDiv && (bus.Op2_i == '0);

    assign w_op1Neg = !w_isUnsigned && bus.Op1_i[WIDTH-1];
    assign w_op2Neg = !w_isUnsigned && bus.Op2_i[WIDTH-1];
    assign w_op1Mag = w_op1Neg ? -bus.Op1_i : bus.Op1_i;
    assign w_op2Mag = w_op2Neg ? -bus.Op2_i : bus.Op2_i;

    // Two guard bits on the multiplicand leave room for the +/-2M partial product.
    assign w_mcandInit = w_isUnsigned ? {2'b00, bus.Op1_i}
                                      : {{2{bus.Op1_i[WIDTH-1]}}, bus.Op1_i};

    // Unsigned multiply runs one extra step for the two zero-extension bits of
    // the multiplier. Those bits recode to {0,0,msb}, i.e. adding M at weight
    // 2^WIDTH. The multiplier is exhausted by then, so this step adds without
    // shifting, and HI/LO come from the same accumulator slice as signed.
    assign w_corrStep = r_unsigned && (r_count == ONE);

    // Booth digit selection from the low three accumulator bits.
    always_comb begin
        w_booth = w_corrStep ? {2'b00, r_acc[0]} : r_acc[2:0];
        w_pp    = '0;
        case (w_booth)
            3'b001, 3'b010: w_pp = r_mcand;
            3'b011:         w_pp = r_mcand << 1;
            3'b100:         w_pp = -(r_mcand << 1);
            3'b101, 3'b110: w_pp = -r_mcand;
            default:        w_pp = '0;
        endcase
    end

    assign w_aSum     = r_acc[AW-1:WIDTH+1] + w_pp;
    assign w_accSum   = {w_aSum, r_acc[WIDTH:0]};
    assign w_accShift = {{2{w_aSum[MW-1]}}, w_accSum[AW-1:2]};
    assign w_accNext  = w_corrStep ? w_accSum : w_accShift;

    // Restoring divide step: remainder in acc[2W-1:W], dividend/quotient in acc[W-1:0].
    assign w_rem     = r_acc[2*WIDTH-1:WIDTH];
    assign w_quo     = r_acc[WIDTH-1:0];
    assign w_shifted = {w_rem, w_quo[WIDTH-1]};
    assign w_diff    = w_shifted - {1'b0, r_mcand[WIDTH-1:0]};
    assign w_fits    = !w_diff[WIDTH];
    assign w_remNext = w_fits ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
    assign w_quoNext = {w_quo[WIDTH-2:0], w_fits};

    assign bus.Stall_o   = w_start || (r_state != IDLE);
    assign bus.DivZero_o = r_divZero;
    assign bus.Res_o     = w_moveFrom ? (bus.ALUCtl_i[1] ? r_lo : r_hi) : '0;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic. Divide by zero resolves in the start cycle and never
    // leaves IDLE; the counter reaching one marks the last busy cycle.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    if (!w_isDiv) begin
                        w_stateNext = MULT;
                    end else if (!w_divByZero) begin
                        w_stateNext = DIV;
                    end
                end
            end
            MULT, DIV: begin
                if (r_count == ONE) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Datapath: operand capture on start, one iteration per busy cycle, HI/LO
    // written only on the final cycle so an aborted op leaves them untouched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count    <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_unsigned <= 1'b0;
            r_negQ     <= 1'b0;
            r_negR     <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_divZero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_divZero  <= w_divByZero;
                        r_unsigned <= w_isUnsigned;
                        if (!w_isDiv) begin
                            r_count <= w_isUnsigned ? K_MU : K_MS;
                            r_acc   <= {{MW{1'b0}}, bus.Op2_i, 1'b0};
                            r_mcand <= w_mcandInit;
                        end else if (w_divByZero) begin
                            r_hi <= bus.Op1_i;
                            r_lo <= '1;
                        end else begin
                            r_count <= K_D;
                            r_acc   <= {{(WIDTH+3){1'b0}}, w_op1Mag};
                            r_mcand <= {2'b00, w_op2Mag};
                            r_negQ  <= w_op1Neg ^ w_op2Neg;
                            r_negR  <= w_op1Neg;
                        end
                    end
                end
                MULT: begin
                    r_acc   <= w_accNext;
                    r_count <= r_count - ONE;
                    if (r_count == ONE) begin
                        r_hi <= w_accNext[2*WIDTH:WIDTH+1];
                        r_lo <= w_accNext[WIDTH:1];
                    end
                end
                DIV: begin
                    r_count <= r_count - ONE;
                    if (r_count == ONE) begin
                        // Sign fix: quotient truncates toward zero, remainder follows the dividend.
                        r_lo <= r_negQ ? -w_quo : w_quo;
                        r_hi <= r_negR ? -w_rem : w_rem;
                    end else begin
                        r_acc <= {3'b000, w_remNext, w_quoNext};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_seq_param.sv
// ---------------------------------------------------------------------------
// tb_multdiv_seq_param
// Directed self-checking bench for multdiv_seq_param. Instantiates a 32-bit
// and a 16-bit unit sharing clock and reset, each on its own interface.
// ---------------------------------------------------------------------------
module tb_multdiv_seq_param;

    localparam logic [3:0] OP_MULT  = 4'b1100;
    localparam logic [3:0] OP_MULTU = 4'b1110;
    localparam logic [3:0] OP_DIV   = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1111;
    localparam logic [3:0] OP_MFHI  = 4'b1000;
    localparam logic [3:0] OP_MFLO  = 4'b1001;
    localparam logic [3:0] OP_NOP   = 4'b0000;

    typedef struct {
        string       name;
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        int          n;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    multdiv_seq_param_if #(.WIDTH(32)) if32 ();
    multdiv_seq_param_if #(.WIDTH(16)) if16 ();

    multdiv_seq_param #(.WIDTH(32)) dut32 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (if32.slave)
    );

    multdiv_seq_param #(.WIDTH(16)) dut16 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (if16.slave)
    );

    always #5 clk = ~clk;

    // Hard stop in case something outside the bounded loops hangs.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic stallOf(input bit w16);
        return w16 ? if16.Stall_o : if32.Stall_o;
    endfunction

    task automatic setNop(input bit w16);
        if (w16) if16.ALUCtl_i = OP_NOP;
        else     if32.ALUCtl_i = OP_NOP;
    endtask

    task automatic startOp(input bit w16, input logic [3:0] ctl,
                           input logic [31:0] a, input logic [31:0] b);
        if (w16) begin
            if16.ALUCtl_i = ctl;
            if16.Op1_i    = a[15:0];
            if16.Op2_i    = b[15:0];
        end else begin
            if32.ALUCtl_i = ctl;
            if32.Op1_i    = a;
            if32.Op2_i    = b;
        end
    endtask

    // Counts stalled cycles starting with the start cycle; returns in the
    // first unstalled cycle, 1 ns after its falling edge.
    task automatic waitDone(input bit w16, output int n);
        #1;
        n = stallOf(w16) ? 1 : 0;
        @(negedge clk);
        setNop(w16);
        #1;
        while (stallOf(w16) && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic readHiLo(input bit w16, output logic [31:0] hi, output logic [31:0] lo);
        if (w16) if16.ALUCtl_i = OP_MFHI; else if32.ALUCtl_i = OP_MFHI;
        #1;
        hi = w16 ? {16'h0000, if16.Res_o} : if32.Res_o;
        if (w16) if16.ALUCtl_i = OP_MFLO; else if32.ALUCtl_i = OP_MFLO;
        #1;
        lo = w16 ? {16'h0000, if16.Res_o} : if32.Res_o;
        setNop(w16);
    endtask

    task automatic doOp(input bit w16, input logic [3:0] ctl, input logic [31:0] a,
                        input logic [31:0] b, output int n,
                        output logic [31:0] hi, output logic [31:0] lo);
        @(negedge clk);
        startOp(w16, ctl, a, b);
        waitDone(w16, n);
        readHiLo(w16, hi, lo);
    endtask

    task automatic test_reset;
        logic [31:0] res;
        rst_n = 1'b0;
        startOp(1'b0, OP_NOP, 32'h0, 32'h0);
        startOp(1'b1, OP_NOP, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (if32.Stall_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_stall32: got %b expected 0", if32.Stall_o);
        end
        checks++;
        if (if16.Stall_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_stall16: got %b expected 0", if16.Stall_o);
        end
        checks++;
        if (if32.DivZero_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_divzero: got %b expected 0", if32.DivZero_o);
        end
        if32.ALUCtl_i = OP_MFHI;
        #1;
        res = if32.Res_o;
        checks++;
        if (res !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_hi: got %h expected 00000000", res);
        end
        if32.ALUCtl_i = OP_MFLO;
        #1;
        res = if32.Res_o;
        checks++;
        if (res !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_lo: got %h expected 00000000", res);
        end
        setNop(1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mult;
        vec_t        v[4];
        int          n;
        logic [31:0] hi, lo;
        v[0] = '{"mult_neg3x7",    OP_MULT,  32'hFFFFFFFD, 32'd7,        17, 32'hFFFFFFFF, 32'hFFFFFFEB};
        v[1] = '{"multu_max",      OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 18, 32'hFFFFFFFE, 32'h00000001};
        v[2] = '{"mult_m1xm1",     OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 17, 32'h00000000, 32'h00000001};
        v[3] = '{"mult_minxmin",   OP_MULT,  32'h80000000, 32'h80000000, 17, 32'h40000000, 32'h00000000};
        foreach (v[i]) begin
            doOp(1'b0, v[i].ctl, v[i].a, v[i].b, n, hi, lo);
            checks++;
            if (n !== v[i].n) begin
                failures++;
                $display("[TB] FAIL %s stall: got %0d cycles expected %0d", v[i].name, n, v[i].n);
            end
            checks++;
            if (hi !== v[i].hi) begin
                failures++;
                $display("[TB] FAIL %s HI: got %h expected %h", v[i].name, hi, v[i].hi);
            end
            checks++;
            if (lo !== v[i].lo) begin
                failures++;
                $display("[TB] FAIL %s LO: got %h expected %h", v[i].name, lo, v[i].lo);
            end
        end
    endtask

    task automatic test_div;
        vec_t        v[5];
        int          n;
        logic [31:0] hi, lo;
        v[0] = '{"div_m7d2",     OP_DIV,  32'hFFFFFFF9, 32'd2,        34, 32'hFFFFFFFF, 32'hFFFFFFFD};
        v[1] = '{"divu_7d2",     OP_DIVU, 32'd7,        32'd2,        34, 32'h00000001, 32'h00000003};
        v[2] = '{"div_min_dm1",  OP_DIV,  32'h80000000, 32'hFFFFFFFF, 34, 32'h00000000, 32'h80000000};
        v[3] = '{"div_100dm7",   OP_DIV,  32'd100,      32'hFFFFFFF9, 34, 32'h00000002, 32'hFFFFFFF2};
        v[4] = '{"divu_max_d16", OP_DIVU, 32'hFFFFFFFF, 32'h00000010, 34, 32'h0000000F, 32'h0FFFFFFF};
        foreach (v[i]) begin
            doOp(1'b0, v[i].ctl, v[i].a, v[i].b, n, hi, lo);
            checks++;
            if (n !== v[i].n) begin
                failures++;
                $display("[TB] FAIL %s stall: got %0d cycles expected %0d", v[i].name, n, v[i].n);
            end
            checks++;
            if (hi !== v[i].hi) begin
                failures++;
                $display("[TB] FAIL %s HI: got %h expected %h", v[i].name, hi, v[i].hi);
            end
            checks++;
            if (lo !== v[i].lo) begin
                failures++;
                $display("[TB] FAIL %s LO: got %h expected %h", v[i].name, lo, v[i].lo);
            end
        end
    endtask

    task automatic test_div_zero;
        int          n;
        logic [31:0] hi, lo;
        doOp(1'b0, OP_DIV, 32'h00001234, 32'h0, n, hi, lo);
        checks++;
        if (n !== 1) begin
            failures++;
            $display("[TB] FAIL dz_stall: got %0d cycles expected 1", n);
        end
        checks++;
        if (hi !== 32'h00001234 || lo !== 32'hFFFFFFFF) begin
            failures++;
            $display("[TB] FAIL dz_hilo: got HI=%h LO=%h expected HI=00001234 LO=ffffffff", hi, lo);
        end
        checks++;
        if (if32.DivZero_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL dz_flag: got %b expected 1", if32.DivZero_o);
        end
        // Flag is sticky and Res_o is zero without a move-from.
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (if32.DivZero_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL dz_hold: got %b expected 1", if32.DivZero_o);
        end
        checks++;
        if (if32.Res_o !== 32'h0) begin
            failures++;
            $display("[TB] FAIL res_nop: got %h expected 00000000", if32.Res_o);
        end
        doOp(1'b0, OP_MULT, 32'd3, 32'd4, n, hi, lo);
        checks++;
        if (if32.DivZero_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL dz_clear_mult: got %b expected 0", if32.DivZero_o);
        end
        checks++;
        if (hi !== 32'h0 || lo !== 32'd12) begin
            failures++;
            $display("[TB] FAIL mult_3x4: got HI=%h LO=%h expected HI=00000000 LO=0000000c", hi, lo);
        end
        doOp(1'b0, OP_DIVU, 32'd5, 32'h0, n, hi, lo);
        checks++;
        if (n !== 1 || if32.DivZero_o !== 1'b1 || hi !== 32'd5 || lo !== 32'hFFFFFFFF) begin
            failures++;
            $display("[TB] FAIL divu_zero: got n=%0d flag=%b HI=%h LO=%h expected n=1 flag=1 HI=00000005 LO=ffffffff",
                     n, if32.DivZero_o, hi, lo);
        end
        doOp(1'b0, OP_DIV, 32'd9, 32'd3, n, hi, lo);
        checks++;
        if (if32.DivZero_o !== 1'b0 || hi !== 32'h0 || lo !== 32'd3) begin
            failures++;
            $display("[TB] FAIL dz_clear_div: got flag=%b HI=%h LO=%h expected flag=0 HI=00000000 LO=00000003",
                     if32.DivZero_o, hi, lo);
        end
    endtask

    task automatic test_async_reset;
        int          n;
        logic [31:0] hi, lo;
        logic [31:0] res;
        // Leave non-zero HI/LO behind so the reset has something to clear.
        doOp(1'b0, OP_DIV, 32'h0000ABCD, 32'h0, n, hi, lo);
        @(negedge clk);
        startOp(1'b0, OP_DIV, 32'd100, 32'd7);
        @(negedge clk);
        setNop(1'b0);
        repeat (9) @(negedge clk);
        #1;
        checks++;
        if (if32.Stall_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ar_busy: got %b expected 1", if32.Stall_o);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (if32.Stall_o !== 1'b0 || if32.DivZero_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ar_flags: got stall=%b divzero=%b expected 0 0", if32.Stall_o, if32.DivZero_o);
        end
        if32.ALUCtl_i = OP_MFHI;
        #1;
        res = if32.Res_o;
        checks++;
        if (res !== 32'h0) begin
            failures++;
            $display("[TB] FAIL ar_hi: got %h expected 00000000", res);
        end
        if32.ALUCtl_i = OP_MFLO;
        #1;
        res = if32.Res_o;
        checks++;
        if (res !== 32'h0) begin
            failures++;
            $display("[TB] FAIL ar_lo: got %h expected 00000000", res);
        end
        setNop(1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        doOp(1'b0, OP_MULT, 32'd5, 32'hFFFFFFFA, n, hi, lo);
        checks++;
        if (n !== 17 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFE2) begin
            failures++;
            $display("[TB] FAIL ar_mult_5xm6: got n=%0d HI=%h LO=%h expected n=17 HI=ffffffff LO=ffffffe2",
                     n, hi, lo);
        end
    endtask

    task automatic test_width16;
        vec_t        v[4];
        int          n;
        logic [31:0] hi, lo;
        v[0] = '{"w16_mult_min",  OP_MULT,  32'h8000, 32'h8000, 9,  32'h4000, 32'h0000};
        v[1] = '{"w16_divu",      OP_DIVU,  32'hFFFF, 32'h0010, 18, 32'h000F, 32'h0FFF};
        v[2] = '{"w16_multu_max", OP_MULTU, 32'hFFFF, 32'hFFFF, 10, 32'hFFFE, 32'h0001};
        v[3] = '{"w16_div_min",   OP_DIV,   32'h8000, 32'hFFFF, 18, 32'h0000, 32'h8000};
        foreach (v[i]) begin
            doOp(1'b1, v[i].ctl, v[i].a, v[i].b, n, hi, lo);
            checks++;
            if (n !== v[i].n) begin
                failures++;
                $display("[TB] FAIL %s stall: got %0d cycles expected %0d", v[i].name, n, v[i].n);
            end
            checks++;
            if (hi !== v[i].hi) begin
                failures++;
                $display("[TB] FAIL %s HI: got %h expected %h", v[i].name, hi, v[i].hi);
            end
            checks++;
            if (lo !== v[i].lo) begin
                failures++;
                $display("[TB] FAIL %s LO: got %h expected %h", v[i].name, lo, v[i].lo);
            end
        end
    endtask

    task automatic test_back_to_back;
        int          n1, n2;
        logic [31:0] hi, lo;
        @(negedge clk);
        startOp(1'b0, OP_MULT, 32'd6, 32'd7);
        waitDone(1'b0, n1);
        // First unstalled cycle: issue the next op immediately.
        startOp(1'b0, OP_DIVU, 32'd42, 32'd5);
        waitDone(1'b0, n2);
        readHiLo(1'b0, hi, lo);
        checks++;
        if (n1 !== 17) begin
            failures++;
            $display("[TB] FAIL b2b_first_stall: got %0d cycles expected 17", n1);
        end
        checks++;
        if (n2 !== 34) begin
            failures++;
            $display("[TB] FAIL b2b_second_stall: got %0d cycles expected 34", n2);
        end
        checks++;
        if (hi !== 32'd2 || lo !== 32'd8) begin
            failures++;
            $display("[TB] FAIL b2b_result: got HI=%h LO=%h expected HI=00000002 LO=00000008", hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_async_reset();
        test_width16();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
